tile_sequencer: RTL

Parametrised top-level sequencer for the systolic CNN array: it runs a full weight-tile × input-tile schedule from a single start command. It drives the input router (IR), weight router (WR) and output router (OR) through route, synchronised pop, compute, drain and output phases. It sits above the three routers and replaces the single-pass top controller, adding runtime tile counts, a computed drain interval, tile indices and an optional watchdog.

---
 rtl/tile_seq_pkg.sv | 28 ++
 rtl/seq_cycle_counter.sv | 23 ++
 rtl/tile_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/tile_seq_pkg.sv
// Shared types and helpers for the tile sequencer: FSM state encoding and
// drain-interval arithmetic derived from the PE array geometry.
package tile_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ROUTE,
    S_WAIT_RDY,
    S_POP,
    S_COMPUTE,
    S_DRAIN,
    S_PSUM,
    S_OUT,
    S_NEXT,
    S_DONE
  } seq_state_e;

  localparam int unsigned DEF_ROWS = 2;
  localparam int unsigned DEF_COLS = 2;
  // Drain counter width for the default 2x2 array; the top re-derives it from its own ROWS/COLS.
  localparam int unsigned DRAIN_W  = $clog2(DEF_ROWS + DEF_COLS);

  // Cycles for the last psum to ripple out of a ROWS x COLS systolic array.
  function automatic int unsigned drain_cycles(input int unsigned rows, input int unsigned cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/seq_cycle_counter.sv
// Up-counter with synchronous clear (dominant over enable) and a terminal-count
// flag raised while the count equals LAST.
module seq_cycle_counter #(
  parameter int W = 4,
  parameter logic [W-1:0] LAST = '1
) (
  input  logic         i_clk,
  input  logic         i_nrst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst)   count <= '0;
    else if (clr)  count <= '0;
    else if (en)   count <= count + 1'b1;
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/tile_sequencer.sv
// Weight-tile x input-tile schedule sequencer driving the IR/WR/OR routers.
// Optional watchdog: define TILE_SEQ_TIMEOUT_EN to abort stalled phases and flag o_error.
module tile_sequencer
  import tile_seq_pkg::*;
#(
  parameter int ROWS           = 2,
  parameter int COLS           = 2,
  parameter int CNT_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  input  logic                 i_reg_clear,
  input  logic                 i_start,
  input  logic [CNT_WIDTH-1:0] i_num_wtiles,
  input  logic [CNT_WIDTH-1:0] i_num_itiles,
  input  logic                 i_ir_ready,
  input  logic                 i_wr_ready,
  input  logic                 i_ir_context_done,
  input  logic                 i_or_done,
  output logic                 o_ir_en,
  output logic                 o_wr_en,
  output logic                 o_ir_pop_en,
  output logic                 o_wr_pop_en,
  output logic                 o_ir_fifo_ptr_reset,
  output logic                 o_psum_out_en,
  output logic                 o_or_en,
  output logic [CNT_WIDTH-1:0] o_wtile_idx,
  output logic [CNT_WIDTH-1:0] o_itile_idx,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error
);

  localparam int DRAIN_CW = $clog2(ROWS + COLS);
  localparam logic [DRAIN_CW-1:0] DRAIN_LAST = DRAIN_CW'(drain_cycles(ROWS, COLS) - 1);

  seq_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] nw_q, nw_d, ni_q, ni_d;
  logic [CNT_WIDTH-1:0] widx_q, widx_d, iidx_q, iidx_d;
  logic                 route_w_q, route_w_d;
  logic                 last_itile, last_wtile;
  logic [DRAIN_CW-1:0]  drain_cnt;
  logic                 drain_tc;

  // Cleared whenever outside DRAIN, so each DRAIN visit starts from zero.
  seq_cycle_counter #(.W(DRAIN_CW), .LAST(DRAIN_LAST)) u_drain_cnt (
    .i_clk (i_clk),
    .i_nrst(i_nrst),
    .clr   (i_reg_clear || (state_q != S_DRAIN)),
    .en    (state_q == S_DRAIN),
    .count (drain_cnt),
    .tc    (drain_tc)
  );

`ifdef TILE_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic            err_q, err_d;
  logic            wd_watch, wd_tc;
  logic [WD_W-1:0] wd_cnt;

  // Watched states are never adjacent, so clearing outside them resets on every state change.
  assign wd_watch = (state_q == S_WAIT_RDY) || (state_q == S_COMPUTE) || (state_q == S_OUT);

  seq_cycle_counter #(.W(WD_W), .LAST(WD_LAST)) u_wd_cnt (
    .i_clk (i_clk),
    .i_nrst(i_nrst),
    .clr   (i_reg_clear || !wd_watch),
    .en    (wd_watch),
    .count (wd_cnt),
    .tc    (wd_tc)
  );

  assign o_error = err_q;
`else
  assign o_error = 1'b0;
`endif

  assign last_itile = !(iidx_q < ni_q - 1'b1);
  assign last_wtile = !(widx_q < nw_q - 1'b1);

  always_comb begin
    state_d   = state_q;
    nw_d      = nw_q;
    ni_d      = ni_q;
    widx_d    = widx_q;
    iidx_d    = iidx_q;
    route_w_d = route_w_q;
`ifdef TILE_SEQ_TIMEOUT_EN
    err_d     = err_q;
`endif
    case (state_q)
      S_IDLE: if (i_start) begin
        state_d   = S_ROUTE;
        nw_d      = (i_num_wtiles == '0) ? CNT_WIDTH'(1) : i_num_wtiles;
        ni_d      = (i_num_itiles == '0) ? CNT_WIDTH'(1) : i_num_itiles;
        widx_d    = '0;
        iidx_d    = '0;
        route_w_d = 1'b1;
      end
      S_ROUTE:    state_d = S_WAIT_RDY;
      S_WAIT_RDY: if (i_ir_ready && i_wr_ready) state_d = S_POP;
      S_POP:      state_d = S_COMPUTE;
      S_COMPUTE:  if (i_ir_context_done) state_d = S_DRAIN;
      S_DRAIN:    if (drain_tc) state_d = S_PSUM;
      S_PSUM:     state_d = S_OUT;
      S_OUT:      if (i_or_done) state_d = S_NEXT;
      S_NEXT: begin
        if (!last_itile) begin
          iidx_d    = iidx_q + 1'b1;
          route_w_d = 1'b0;
          state_d   = S_ROUTE;
        end else if (!last_wtile) begin
          widx_d    = widx_q + 1'b1;
          iidx_d    = '0;
          route_w_d = 1'b1;
          state_d   = S_ROUTE;
        end else begin
          state_d   = S_DONE;
        end
      end
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
`ifdef TILE_SEQ_TIMEOUT_EN
    if (wd_watch && wd_tc) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end
`endif
    if (i_reg_clear) begin
      state_d   = S_IDLE;
      nw_d      = '0;
      ni_d      = '0;
      widx_d    = '0;
      iidx_d    = '0;
      route_w_d = 1'b0;
`ifdef TILE_SEQ_TIMEOUT_EN
      err_d     = 1'b0;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q   <= S_IDLE;
      nw_q      <= '0;
      ni_q      <= '0;
      widx_q    <= '0;
      iidx_q    <= '0;
      route_w_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      nw_q      <= nw_d;
      ni_q      <= ni_d;
      widx_q    <= widx_d;
      iidx_q    <= iidx_d;
      route_w_q <= route_w_d;
    end
  end

`ifdef TILE_SEQ_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) err_q <= 1'b0;
    else         err_q <= err_d;
  end
`endif

  assign o_ir_en             = (state_q == S_ROUTE);
  assign o_wr_en             = (state_q == S_ROUTE) && route_w_q;
  assign o_ir_pop_en         = (state_q == S_POP);
  assign o_wr_pop_en         = (state_q == S_POP);
  assign o_ir_fifo_ptr_reset = (state_q == S_NEXT) && last_itile && !last_wtile;
  assign o_psum_out_en       = (state_q == S_PSUM);
  assign o_or_en             = (state_q == S_OUT);
  assign o_wtile_idx         = widx_q;
  assign o_itile_idx         = iidx_q;
  assign o_busy              = (state_q != S_IDLE);
  assign o_done              = (state_q == S_DONE);

endmodule
